button_debouncer: RTL and testbench



---
 rtl/button_pkg.sv | 15 +
 rtl/sync_chain.sv | 20 ++
 rtl/button_debouncer.sv | 117 +++++++++++
 tb/tb_button_debouncer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button debouncer.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } debounce_state_t;

    localparam int DEF_SYNC_STAGES       = 2;
    localparam int DEF_DEBOUNCE_CYCLES   = 1000000;
    localparam int DEF_LONG_PRESS_CYCLES = 100000000;

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronise a raw button pin and qualify level changes with a stability counter.
// Optional long-press detector enabled by defining BUTTON_DEBOUNCER_LONG_PRESS_EN.
module button_debouncer
    import button_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W             = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic button_clean,
    output logic busy,
    output logic long_press
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1) begin : g_bad_param
        $error("button_debouncer: illegal parameter value");
    end

    logic            button_sync;
    debounce_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic            clean_next;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (button_raw),
        .q     (button_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE_LOW;
            cnt          <= '0;
            button_clean <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            button_clean <= clean_next;
            busy         <= (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
        end
    end

    // A sample matching the current clean level aborts qualification.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clean_next = button_clean;
        case (state)
            IDLE_LOW: begin
                if (button_sync) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!button_sync) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (!button_sync) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    clean_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_LOW: begin
                if (button_sync) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    clean_next = 1'b0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);

    logic [LP_W-1:0] lp_cnt;

    // Clearing on clean_next lets long_press drop on the same edge clean falls.
    always_ff @(posedge clk) begin
        if (reset || !clean_next) begin
            lp_cnt     <= '0;
            long_press <= 1'b0;
        end else if (button_clean && lp_cnt != LP_W'(LONG_PRESS_CYCLES)) begin
            lp_cnt     <= lp_cnt + 1'b1;
            long_press <= (lp_cnt == LP_W'(LONG_PRESS_CYCLES - 1));
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with a sample-history reference model.
module tb_button_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LPC  = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic button_raw = 1'b1;
    logic button_clean, busy, long_press;

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .SYNC_STAGES       (SYNC),
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LPC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_raw   (button_raw),
        .button_clean (button_clean),
        .busy         (busy),
        .long_press   (long_press)
    );

    always #5 clk = ~clk;

    // Reference: a 2-deep sample pipe, and clean flips once the last DEB
    // samples seen after the pipe all disagree with the current clean level.
    logic m_s0 = 1'b0, m_s1 = 1'b0;
    logic m_clean = 1'b0, m_busy = 1'b0, m_lp = 1'b0;
    int   m_hi = 0;
    bit   m_ready = 1'b0;
    logic hist[$];

    always @(posedge clk) begin
        if (reset) begin
            m_s0 = 1'b0; m_s1 = 1'b0;
            m_clean = 1'b0; m_busy = 1'b0; m_lp = 1'b0; m_hi = 0;
            hist.delete();
            m_ready = 1'b1;
        end else begin
            logic smp, old, flip;
            smp = m_s1;
            old = m_clean;
            hist.push_back(smp);
            if (hist.size() > DEB) void'(hist.pop_front());
            flip = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] == old) flip = 1'b0;
            if (flip) m_clean = !old;
            m_busy = !flip && (smp != old);
            if (!m_clean) begin
                m_hi = 0;
                m_lp = 1'b0;
            end else if (old) begin
                m_hi++;
            end
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
            if (m_clean && m_hi >= LPC) m_lp = 1'b1;
`endif
            m_s1 = m_s0;
            m_s0 = button_raw;
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            checks++;
            if (button_clean !== m_clean || busy !== m_busy || long_press !== m_lp) begin
                errors++;
                $display("FAIL model t=%0t clean/busy/lp got %b%b%b want %b%b%b",
                         $time, button_clean, busy, long_press, m_clean, m_busy, m_lp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, act, exp);
        end
    endtask

    localparam logic [4:0] BOUNCE = 5'b01101; // bit 0 first: 1,0,1,1,0

    initial begin
        // Reset with the pin already high.
        repeat (3) tick();
        lit("rst_clean", button_clean, 1'b0);
        lit("rst_busy", busy, 1'b0);
        lit("rst_lp", long_press, 1'b0);
        reset = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 2) lit("pwr_busy_e2", busy, 1'b0);
            if (e >= 3 && e <= 5) lit("pwr_busy_e345", busy, 1'b1);
            if (e == 5) lit("pwr_clean_e5", button_clean, 1'b0);
            if (e == 6) begin
                lit("pwr_clean_e6", button_clean, 1'b1);
                lit("pwr_busy_e6", busy, 1'b0);
            end
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
            if (e == 15) lit("lp_e15", long_press, 1'b0);
            if (e == 16) lit("lp_e16", long_press, 1'b1);
`else
            if (e == 16) lit("lp_off", long_press, 1'b0);
`endif
        end

        // Clean release.
        button_raw = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) lit("rel_clean_e5", button_clean, 1'b1);
            if (e == 6) begin
                lit("rel_clean_e6", button_clean, 1'b0);
                lit("rel_lp_e6", long_press, 1'b0);
            end
        end
        repeat (3) tick();

        // Clean 0->1 step, then hold.
        button_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 5) lit("step_clean_e5", button_clean, 1'b0);
            if (e == 6) lit("step_clean_e6", button_clean, 1'b1);
            if (e == 10) lit("step_busy_e10", busy, 1'b0);
        end

        // Release with a 3-cycle glitch back high.
        for (int e = 1; e <= 12; e++) begin
            button_raw = (e >= 3 && e <= 5);
            tick();
            if (e == 10) lit("glitch_clean_e10", button_clean, 1'b1);
            if (e == 11) lit("glitch_clean_e11", button_clean, 1'b0);
        end
        repeat (4) tick();

        // Bounce 1,0,1,1,0 then steady high.
        for (int e = 1; e <= 12; e++) begin
            button_raw = (e <= 5) ? BOUNCE[e-1] : 1'b1;
            tick();
            if (e == 10) lit("bounce_clean_e10", button_clean, 1'b0);
            if (e == 11) lit("bounce_clean_e11", button_clean, 1'b1);
        end

        // Reset mid-qualification (WAIT_HIGH, cnt=2), pin held high.
        button_raw = 1'b0;
        repeat (8) tick();
        button_raw = 1'b1;
        repeat (4) tick();
        lit("midrst_busy_pre", busy, 1'b1);
        reset = 1'b1;
        tick();
        lit("midrst_busy", busy, 1'b0);
        lit("midrst_clean", button_clean, 1'b0);
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) lit("requal_clean_e5", button_clean, 1'b0);
            if (e == 6) lit("requal_clean_e6", button_clean, 1'b1);
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
